// File: rtl/uart_byte_rx_if.sv
// uart_byte_rx_if: byte-delivery bundle from the UART receiver to its consumer.
//   rx_valid      1-cycle pulse, rx_data holds a new good byte
//   rx_data       last good byte, stable until the next rx_valid
//   rx_frame_err  1-cycle pulse, stop bit sampled low
//   rx_busy       receiver is mid-frame (or waiting out a break)
// master: the receiver (drives everything); slave: the consumer.
interface uart_byte_rx_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_frame_err;
  logic       rx_busy;

  modport master (output rx_valid, output rx_data, output rx_frame_err, output rx_busy);
  modport slave  (input  rx_valid, input  rx_data, input  rx_frame_err, input  rx_busy);
endinterface

// File: rtl/uart_byte_rx.sv
// uart_byte_rx: 8N1 UART receiver, LSB first, oversampled at clk rate.
//   clk       system clock
//   rstb      asynchronous reset, active-low
//   uart_rxd  asynchronous serial line, idle high
//   rx        uart_byte_rx_if.master: rx_valid / rx_data / rx_frame_err / rx_busy
// Samples each bit at its centre, counted from the synchronised start edge.
// A stop bit sampled low flags a framing error and parks the FSM until the
// line returns high, so a held-low line cannot re-trigger frames.
module uart_byte_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          uart_rxd,
  uart_byte_rx_if.master rx
);

  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  state_t                 state_q, state_d;
  logic [CW-1:0]          cyc_q, cyc_d;
  logic [2:0]             bit_q, bit_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             data_q, data_d;
  logic                   valid_q, valid_d;
  logic                   err_q, err_d;
  logic                   busy_q, busy_d;
  logic                   rxs;

  assign rxs = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], uart_rxd};
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          cyc_d   = '0;
        end
      end
      S_START: begin
        if (cyc_q == HALF_M1) begin
          cyc_d = '0;
          bit_d = '0;
          // Line back high at mid start bit: treat as a glitch.
          state_d = rxs ? S_IDLE : S_DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cyc_q == BIT_M1) begin
          cyc_d          = '0;
          shift_d[bit_q] = rxs;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cyc_q == BIT_M1) begin
          cyc_d = '0;
          if (rxs) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rxs) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q  <= '1;
      state_q <= S_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign rx.rx_valid     = valid_q;
  assign rx.rx_data      = data_q;
  assign rx.rx_frame_err = err_q;
  assign rx.rx_busy      = busy_q;

endmodule

// File: tb/tb_uart_byte_rx.sv
// tb_uart_byte_rx: self-checking bench for uart_byte_rx (CLKS_PER_BIT=16, SYNC_STAGES=2).
// A frame-level line driver pushes one expected event per frame into a queue;
// a monitor on the falling clock edge pops and compares each rx_valid/rx_frame_err
// pulse and checks rx_data stability between pulses.
module tb_uart_byte_rx;

  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic rstb = 1'b0;
  logic uart_rxd = 1'b1;

  uart_byte_rx_if rx_if ();

  uart_byte_rx #(
    .CLKS_PER_BIT(CPB),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rstb    (rstb),
    .uart_rxd(uart_rxd),
    .rx      (rx_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc_count = 0;

  always @(posedge clk) cyc_count <= cyc_count + 1;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         fall;
    logic       chk_lat;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] mon_data = 8'h00;   // byte the monitor expects on rx_data between pulses
  logic [7:0] send_last = 8'h00;  // last good byte as seen by the sending side
  logic       prev_pulse = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (rstb) begin
      if (rx_if.rx_valid || rx_if.rx_frame_err) begin
        chk("exclusive", {31'd0, rx_if.rx_valid & rx_if.rx_frame_err}, 32'd0);
        chk("pulse_width", {31'd0, prev_pulse}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, rx_if.rx_valid, rx_if.rx_frame_err}, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("pulse_kind", {31'd0, rx_if.rx_frame_err}, {31'd0, e.is_err});
          chk("pulse_data", {24'd0, rx_if.rx_data}, {24'd0, e.data});
          mon_data = e.data;
          if (e.chk_lat) begin
            int lat;
            lat = cyc_count - e.fall;
            checks++;
            if (lat < 154 || lat > 156) begin
              errors++;
              $display("FAIL latency: got %0d clks, expected 154..156", lat);
            end
          end
        end
      end else begin
        chk("data_stable", {24'd0, rx_if.rx_data}, {24'd0, mon_data});
      end
      prev_pulse = rx_if.rx_valid | rx_if.rx_frame_err;
    end else begin
      prev_pulse = 1'b0;
    end
  end

  // Drive one frame. Bit edges are placed at round(n*p100/100) clocks, so
  // p100 is the bit period in hundredths of a clock.
  task automatic send_frame(input logic [7:0] d, input int unsigned p100, input logic stop_bit,
                            input int unsigned hold_low, input logic use_exp,
                            input logic exp_err, input logic [7:0] exp_data);
    logic [9:0] bits;
    int unsigned t;
    int unsigned end_t;
    exp_t e;
    bits = {stop_bit, d, 1'b0};
    @(negedge clk);
    if (use_exp) begin
      e.is_err  = exp_err;
      e.data    = exp_data;
      e.fall    = cyc_count;
      e.chk_lat = (p100 == 1600);
      exp_q.push_back(e);
    end
    t = 0;
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      end_t = ((i + 1) * p100 + 50) / 100;
      while (t < end_t) begin
        @(negedge clk);
        t++;
      end
    end
    if (hold_low != 0) begin
      uart_rxd = 1'b0;
      repeat (hold_low) @(negedge clk);
      chk("busy_in_break", {31'd0, rx_if.rx_busy}, 32'd1);
    end
    uart_rxd = 1'b1;
  endtask

  task automatic idle(input int unsigned n);
    uart_rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_empty(input int unsigned budget);
    int unsigned n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("pending_events", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  typedef struct {
    logic [7:0]  data;
    int unsigned p100;
    logic        stop_bit;
    int unsigned hold;
    int unsigned gap;
    logic        exp_err;
    logic [7:0]  exp_data;
  } vec_t;

  vec_t vecs[9];
  int unsigned periods[3];

  initial begin
    // data, period, stop, hold, gap, expected: err, byte on rx_data
    vecs[0] = '{8'hA5, 1600, 1'b1,   0, 20, 1'b0, 8'hA5};
    vecs[1] = '{8'h00, 1600, 1'b1,   0,  0, 1'b0, 8'h00};  // back-to-back
    vecs[2] = '{8'hFF, 1600, 1'b1,   0,  0, 1'b0, 8'hFF};
    vecs[3] = '{8'h5A, 1600, 1'b1,   0, 20, 1'b0, 8'h5A};
    vecs[4] = '{8'h12, 1600, 1'b1,   0, 20, 1'b0, 8'h12};
    vecs[5] = '{8'h3C, 1600, 1'b0, 200, 40, 1'b1, 8'h12};  // rx_data keeps 0x12
    vecs[6] = '{8'h81, 1600, 1'b1,   0, 20, 1'b0, 8'h81};
    vecs[7] = '{8'h96, 1536, 1'b1,   0, 20, 1'b0, 8'h96};  // 4% fast
    vecs[8] = '{8'h69, 1664, 1'b1,   0, 20, 1'b0, 8'h69};  // 4% slow
    periods[0] = 1536;
    periods[1] = 1600;
    periods[2] = 1664;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset_outputs", {21'd0, rx_if.rx_valid, rx_if.rx_data, rx_if.rx_frame_err, rx_if.rx_busy}, 32'd0);
    rstb = 1'b1;
    idle(10);
    chk("idle_busy", {31'd0, rx_if.rx_busy}, 32'd0);

    // Directed table.
    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].data, vecs[i].p100, vecs[i].stop_bit, vecs[i].hold,
                 1'b1, vecs[i].exp_err, vecs[i].exp_data);
      if (vecs[i].gap != 0) begin
        idle(vecs[i].gap);
        wait_empty(400);
        chk("busy_after_frame", {31'd0, rx_if.rx_busy}, 32'd0);
      end
    end
    send_last = 8'h69;

    // Glitch: 4 clocks low, then a long idle; nothing may be reported.
    @(negedge clk);
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    idle(400);
    chk("glitch_busy", {31'd0, rx_if.rx_busy}, 32'd0);
    chk("glitch_data", {24'd0, rx_if.rx_data}, 32'h69);

    // Reset in the middle of bit 4 of 0x77, held until the frame has passed.
    fork
      send_frame(8'h77, 1600, 1'b1, 0, 1'b0, 1'b0, 8'h00);
      begin
        repeat (5 * CPB + 8) @(negedge clk);
        rstb = 1'b0;
        #1;
        chk("midframe_reset_outputs",
            {21'd0, rx_if.rx_valid, rx_if.rx_data, rx_if.rx_frame_err, rx_if.rx_busy}, 32'd0);
        exp_q.delete();
        mon_data  = 8'h00;
        send_last = 8'h00;
      end
    join
    repeat (3) @(negedge clk);
    chk("held_reset_outputs",
        {21'd0, rx_if.rx_valid, rx_if.rx_data, rx_if.rx_frame_err, rx_if.rx_busy}, 32'd0);
    rstb = 1'b1;
    idle(20);
    send_frame(8'hC3, 1600, 1'b1, 0, 1'b1, 1'b0, 8'hC3);
    idle(20);
    wait_empty(400);
    send_last = 8'hC3;

    // Random frames against the frame-level model.
    for (int n = 0; n < 40; n++) begin
      logic [7:0]  d;
      logic        stop_bit;
      int unsigned p;
      d        = 8'($urandom);
      stop_bit = ($urandom_range(0, 7) != 0);
      p        = periods[$urandom_range(0, 2)];
      send_frame(d, p, stop_bit, stop_bit ? 0 : 30, 1'b1, !stop_bit, stop_bit ? d : send_last);
      if (stop_bit) send_last = d;
      idle(6 + $urandom_range(0, 20));
    end
    idle(20);
    wait_empty(500);
    chk("final_busy", {31'd0, rx_if.rx_busy}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
